// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-side PC logic: datapath width, PC step and
// the redirect FSM state type.
package pc_redirect_unit_pkg;

   localparam int                XLEN    = 32;
   localparam logic [XLEN-1:0]   PC_STEP = 32'd4;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   // Jump targets always have bit 0 cleared, as JALR does.
   function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating event counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential advance, branch/jump redirect with 1-cycle latency,
// pipeline flush strobes, and a one-entry buffer for redirects imem cannot take.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             ex_valid_i,
   input  logic             branch_taken_i,
   input  logic [XLEN-1:0]  branch_target_i,
   input  logic             imem_ready_i,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  pc_plus4_o,
   output logic             fetch_valid_o,
   output logic             flush_ifid_o,
   output logic             flush_idex_o,
   output logic             misaligned_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   state_e            r_state;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_pend_tgt;
   logic              r_fetch_valid;
   logic              r_misaligned;

   logic              w_take;
   logic              w_accept;
   logic [XLEN-1:0]   w_tgt;
   logic [XLEN-1:0]   w_pc_plus4;

   // NOTE: every signal driven here gets a value on every path, so no latch
   // can be inferred.
   always_comb begin
      w_take     = ex_valid_i & branch_taken_i;
      w_accept   = w_take & (r_state == ST_RUN);
      w_tgt      = clear_lsb(branch_target_i);
      w_pc_plus4 = r_pc + PC_STEP;
   end

   // A take seen in PEND is dropped: the flush issued on entry guarantees a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_pend_tgt    <= '0;
         r_fetch_valid <= 1'b0;
         r_misaligned  <= 1'b0;
      end else begin
         r_misaligned <= w_accept & branch_target_i[1];
         unique case (r_state)
            ST_RUN: begin
               if (w_take) begin
                  if (imem_ready_i) begin
                     r_pc          <= w_tgt;
                     r_fetch_valid <= 1'b1;
                  end else begin
                     r_pend_tgt    <= w_tgt;
                     r_state       <= ST_PEND;
                     r_fetch_valid <= 1'b0;
                  end
               end else begin
                  r_fetch_valid <= 1'b1;
                  if (imem_ready_i && !stall_i) begin
                     r_pc <= w_pc_plus4;
                  end
               end
            end
            ST_PEND: begin
               if (imem_ready_i) begin
                  r_pc          <= r_pend_tgt;
                  r_state       <= ST_RUN;
                  r_fetch_valid <= 1'b1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_redirect_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_accept),
      .o_count (redirect_cnt_o)
   );

   assign pc_o          = r_pc;
   assign pc_plus4_o    = w_pc_plus4;
   assign fetch_valid_o = r_fetch_valid;
   assign flush_ifid_o  = w_accept;
   assign flush_idex_o  = w_accept;
   assign misaligned_o  = r_misaligned;

endmodule
